dmem_port_arbiter: RTL and testbench

- Shares the single-port synchronous dmem between two requesters: the processor (port P) and a loader/debug master (port D).
- P has priority. D is served in idle P cycles.
- A bounded-wait counter forces a one-cycle processor stall, so D cannot starve.
- Sits between processor/debug logic and dmem; runs on the same clock as processor and dmem.

---
 rtl/dmem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter: shares one synchronous dmem port between the processor
// (P, priority) and a loader/debug master (D) with a bounded-wait force.
// Optional: define DMEM_ARB_STATS_EN for stat_force/stat_dgrant counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_valid,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_address,
    input  logic [DATA_W-1:0] p_data,
    output logic [DATA_W-1:0] p_q,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_wren,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_data,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_force,
    output logic [15:0]       stat_dgrant
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        p_stall_q;
    logic        d_rvalid_q;
    logic        gnt_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gnt_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (d_req && !p_valid) begin
                    gnt_d   = 1'b1;
                    state_d = d_wren ? ST_IDLE : ST_RESP;
                end else if (d_req) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!d_req) begin
                    state_d = ST_IDLE;
                end else if (!p_valid) begin
                    gnt_d   = 1'b1;
                    state_d = d_wren ? ST_IDLE : ST_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_FORCE: begin
                // d_req is held until granted; the guard keeps d_gnt off if D withdrew anyway
                if (d_req) begin
                    gnt_d   = 1'b1;
                    state_d = d_wren ? ST_IDLE : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            p_stall_q  <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            p_stall_q  <= (state_d == ST_FORCE);
            d_rvalid_q <= (state_d == ST_RESP);
        end
    end

    // The grant is combinational, so it must also be masked while reset is held
    assign d_gnt    = gnt_d & reset;
    assign p_stall  = p_stall_q;
    assign d_rvalid = d_rvalid_q;
    assign d_q      = d_rvalid_q ? mem_q : '0;
    assign p_q      = mem_q;

    assign mem_address = d_gnt ? d_address : p_address;
    assign mem_data    = d_gnt ? d_data    : p_data;
    assign mem_wren    = d_gnt ? d_wren    : (p_wren & p_valid & ~p_stall_q);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_force_q;
    logic [15:0] stat_dgrant_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_force_q  <= 16'd0;
            stat_dgrant_q <= 16'd0;
        end else begin
            if (p_stall_q && (stat_force_q != 16'hFFFF)) begin
                stat_force_q <= stat_force_q + 16'd1;
            end
            if (d_gnt && (stat_dgrant_q != 16'hFFFF)) begin
                stat_dgrant_q <= stat_dgrant_q + 16'd1;
            end
        end
    end

    assign stat_force  = stat_force_q;
    assign stat_dgrant = stat_dgrant_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter: directed and random stimulus against a cycle-level
// reference model of the dmem arbitration rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p_valid = 1'b0, p_wren = 1'b0;
    logic [11:0] p_address = '0;
    logic [31:0] p_data = '0;
    logic [31:0] p_q;
    logic        p_stall;
    logic        d_req = 1'b0, d_wren = 1'b0;
    logic [11:0] d_address = '0;
    logic [31:0] d_data = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_force, stat_dgrant;
`endif

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .p_valid(p_valid), .p_wren(p_wren), .p_address(p_address), .p_data(p_data),
        .p_q(p_q), .p_stall(p_stall),
        .d_req(d_req), .d_wren(d_wren), .d_address(d_address), .d_data(d_data),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_q(d_q),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
`ifdef DMEM_ARB_STATS_EN
        , .stat_force(stat_force), .stat_dgrant(stat_dgrant)
`endif
    );

    always #5 clock = ~clock;

    // Environment dmem: registered read of the old contents
    bit [31:0] mem [0:4095];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    int total = 0;
    int bad   = 0;

    // Reference model: how long D has been blocked, and the memory it should see
    bit [31:0] ref_mem [0:4095];
    int        m_wait  = 0;
    bit        m_force = 1'b0;
    bit        m_rv    = 1'b0;
    bit [31:0] m_rq    = '0;
    int        m_stf   = 0;
    int        m_stg   = 0;

    logic        obs_gnt, obs_stall, obs_rv, obs_mwren;
    logic [31:0] obs_dq;
    logic [11:0] obs_maddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait  = 0;
        m_force = 1'b0;
        m_rv    = 1'b0;
        m_stf   = 0;
        m_stg   = 0;
    endtask

    task automatic cycle();
        logic        e_stall, e_gnt, e_mwren;
        logic [11:0] e_maddr;
        logic [31:0] e_mdata;
        @(negedge clock);
        e_stall = m_force;
        e_gnt   = d_req && (m_force || !p_valid);
        e_mwren = e_gnt ? d_wren : (p_wren && p_valid && !e_stall);
        e_maddr = e_gnt ? d_address : p_address;
        e_mdata = e_gnt ? d_data : p_data;
        obs_gnt = d_gnt; obs_stall = p_stall; obs_rv = d_rvalid;
        obs_dq = d_q; obs_maddr = mem_address; obs_mwren = mem_wren;
        chk("p_stall", 32'(p_stall), 32'(e_stall));
        chk("d_gnt", 32'(d_gnt), 32'(e_gnt));
        chk("d_rvalid", 32'(d_rvalid), 32'(m_rv));
        chk("d_q", d_q, m_rv ? m_rq : 32'h0);
        chk("mem_wren", 32'(mem_wren), 32'(e_mwren));
        chk("mem_address", 32'(mem_address), 32'(e_maddr));
        chk("mem_data", mem_data, e_mdata);
        chk("p_q", p_q, mem_q);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_force", 32'(stat_force), 32'(m_stf));
        chk("stat_dgrant", 32'(stat_dgrant), 32'(m_stg));
        if (e_stall && m_stf < 65535) m_stf++;
        if (e_gnt && m_stg < 65535) m_stg++;
`endif
        m_rv = e_gnt && !d_wren;
        if (m_rv) m_rq = ref_mem[d_address];
        if (e_mwren) ref_mem[e_maddr] = e_mdata;
        if (e_gnt || !d_req) begin
            m_wait  = 0;
            m_force = 1'b0;
        end else begin
            m_wait++;
            m_force = (m_wait == MAX_WAIT + 1);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_d(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] dt);
        d_req = req; d_wren = wr; d_address = a; d_data = dt;
    endtask

    task automatic set_p(input logic v, input logic wr, input logic [11:0] a, input logic [31:0] dt);
        p_valid = v; p_wren = wr; p_address = a; p_data = dt;
    endtask

    initial begin
        int gcyc;
        bit stall_seen;

        // Reset state
        #12;
        chk("rst_p_stall", 32'(p_stall), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_d_q", d_q, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();

        // Preload 0x010 through D, then read it back with P idle
        set_d(1, 1, 12'h010, 32'hDEADBEEF);
        cycle();
        set_d(1, 0, 12'h010, 32'h0);
        cycle();
        chk("s1_gnt_c0", 32'(obs_gnt), 32'h1);
        set_d(0, 0, 12'h000, 32'h0);
        cycle();
        chk("s1_rvalid_c1", 32'(obs_rv), 32'h1);
        chk("s1_dq_c1", obs_dq, 32'hDEADBEEF);
        chk("s1_no_stall", 32'(obs_stall), 32'h0);

        // P continuously writing; D write blocked until the forced grant
        set_p(1, 1, 12'h020, 32'h000000AA);
        set_d(1, 1, 12'h020, 32'h5);
        gcyc = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_gnt && gcyc < 0) begin
                gcyc = k;
                chk("s2_force_stall", 32'(obs_stall), 32'h1);
                chk("s2_force_addr", 32'(obs_maddr), 32'h020);
                chk("s2_force_wren", 32'(obs_mwren), 32'h1);
                d_req = 1'b0;
            end else if (gcyc >= 0) begin
                p_valid = 1'b0;
            end
            if (gcyc >= 0 && k > gcyc + 1) break;
        end
        chk("s2_grant_cycle", 32'(gcyc), 32'(MAX_WAIT + 1));
        chk("s2_p_lands_last", mem[12'h020], 32'h000000AA);
`ifdef DMEM_ARB_STATS_EN
        chk("s2_stat_force", 32'(stat_force), 32'h1);
`endif

        // P toggling: D gets the first idle P cycle, no stall
        set_d(1, 0, 12'h010, 32'h0);
        set_p(1, 0, 12'h100, 32'h0);
        cycle();
        chk("s3_blocked", 32'(obs_gnt), 32'h0);
        p_valid = 1'b0;
        cycle();
        chk("s3_gnt", 32'(obs_gnt), 32'h1);
        chk("s3_no_stall", 32'(obs_stall), 32'h0);
        d_req = 1'b0;
        cycle();
        chk("s3_dq", obs_dq, 32'hDEADBEEF);

        // Back-to-back D writes then reads at 0x000..0x003
        for (int i = 0; i < 4; i++) begin
            set_d(1, 1, 12'(i), 32'h1000 + 32'(i));
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_d(1, 0, 12'(i), 32'h0);
            else set_d(0, 0, 12'h0, 32'h0);
            cycle();
            chk("s4_gnt", 32'(obs_gnt), (i < 4) ? 32'h1 : 32'h0);
            chk("s4_rvalid", 32'(obs_rv), (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) chk("s4_dq", obs_dq, 32'h1000 + 32'(i - 1));
        end

        // Reset asserted while in FORCE
        set_p(1, 0, 12'h200, 32'h0);
        set_d(1, 0, 12'h001, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (m_force) break;
            cycle();
        end
        chk("s5_reach_force", 32'(m_force), 32'h1);
        chk("s5_stall_before", 32'(p_stall), 32'h1);
        #1;
        reset = 1'b0;
        p_valid = 1'b0;
        #1;
        chk("s5_rst_stall", 32'(p_stall), 32'h0);
        chk("s5_rst_gnt", 32'(d_gnt), 32'h0);
        chk("s5_rst_rvalid", 32'(d_rvalid), 32'h0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        cycle();
        chk("s5_post_gnt", 32'(obs_gnt), 32'h1);
        d_req = 1'b0;
        cycle();
        chk("s5_post_dq", obs_dq, 32'h1001);

        // Random traffic: D obeys hold-until-grant, P repeats stalled accesses
        for (int n = 0; n < 3000; n++) begin
            cycle();
            if (d_req && obs_gnt) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 2) == 0)
                set_d(1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
            if (!obs_stall)
                set_p(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      12'($urandom_range(0, 15)), $urandom);
        end
        set_d(0, 0, 12'h0, 32'h0);
        set_p(0, 0, 12'h0, 32'h0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
